// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Bundles the fetch-stage signals: PC, no-op stage handshake,
//             redirect targets, and the IF/ID register outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instr_in;
  logic              IF_noOp;
  logic              IF_prenoOp;
  logic [1:0]        pc_src;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] jr_target;
  logic              flush;
  logic [31:0]       ID_instr;
  logic [ADDR_W-1:0] ID_pc4;
  logic              ID_noOp;
  logic              ID_preNoOp;
  logic [CNT_W-1:0]  stall_count;

  // Driver side: supplies instructions, control and targets
  modport master (
    input  pc, ID_instr, ID_pc4, ID_noOp, ID_preNoOp, stall_count,
    output instr_in, IF_noOp, IF_prenoOp, pc_src, branch_target,
           jump_target, jr_target, flush
  );

  // Fetch stage side
  modport slave (
    output pc, ID_instr, ID_pc4, ID_noOp, ID_preNoOp, stall_count,
    input  instr_in, IF_noOp, IF_prenoOp, pc_src, branch_target,
           jump_target, jr_target, flush
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch (PC ownership) plus IF/ID pipeline register.
//             Holds or redirects the PC so bubbled instructions are re-fetched
//             and counts the cycles the PC was held (saturating).
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  wire logic    clk,
  input  wire logic    reset,
  fetch_stage_if.slave bus
);

  localparam logic [31:0] C_NOP = 32'h2000_0000;

  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_id_instr;
  logic [ADDR_W-1:0] r_id_pc4;
  logic              r_id_noop;
  logic              r_id_prenoop;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_redirect;
  logic              w_hold;

  // pc+4 wraps naturally at the top of the address space
  assign w_pc4      = r_pc + ADDR_W'(4);
  assign w_redirect = (bus.pc_src != 2'b00);
  // A redirect always beats a re-fetch hold (e.g. JR resolving in a bubble slot)
  assign w_hold     = ~w_redirect & (bus.IF_prenoOp | r_id_noop);

  // Select the redirect target and compute the next PC by priority
  always_comb begin
    w_target = w_pc4;
    case (bus.pc_src)
      2'b01:   w_target = bus.branch_target;
      2'b10:   w_target = bus.jump_target;
      2'b11:   w_target = bus.jr_target;
      default: w_target = w_pc4;
    endcase

    w_pc_next = w_pc4;
    if (w_redirect) begin
      w_pc_next = {w_target[ADDR_W-1:2], 2'b00};
    end else if (w_hold) begin
      w_pc_next = r_pc;
    end
  end

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // IF/ID register; flush squashes the instruction and its bubble flags only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_instr   <= C_NOP;
      r_id_pc4     <= '0;
      r_id_noop    <= 1'b0;
      r_id_prenoop <= 1'b0;
    end else begin
      r_id_pc4 <= w_pc4;
      if (bus.flush) begin
        r_id_instr   <= C_NOP;
        r_id_noop    <= 1'b0;
        r_id_prenoop <= 1'b0;
      end else begin
        r_id_instr   <= bus.instr_in;
        r_id_noop    <= bus.IF_noOp;
        r_id_prenoop <= bus.IF_prenoOp;
      end
    end
  end

  // Saturating count of held-PC cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.pc          = r_pc;
  assign bus.ID_instr    = r_id_instr;
  assign bus.ID_pc4      = r_id_pc4;
  assign bus.ID_noOp     = r_id_noop;
  assign bus.ID_preNoOp  = r_id_prenoop;
  assign bus.stall_count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed scoreboard bench for fetch_stage. The driver pushes
//             hand-computed expectations tagged with the sample slot at which
//             they must hold; a separate monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] C_NOP = 32'h2000_0000;
  localparam int SEL_PC = 0, SEL_INSTR = 1, SEL_PC4 = 2, SEL_NOOP = 3,
                 SEL_PRE = 4, SEL_STALL = 5;

  typedef struct {
    int          tag;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  exp_t q[$];

  fetch_stage_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index, bumped on every rising edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      SEL_PC:    return bus.pc;
      SEL_INSTR: return bus.ID_instr;
      SEL_PC4:   return bus.ID_pc4;
      SEL_NOOP:  return {31'b0, bus.ID_noOp};
      SEL_PRE:   return {31'b0, bus.ID_preNoOp};
      default:   return {16'b0, bus.stall_count};
    endcase
  endfunction

  // Compare every queued expectation due at this slot
  task automatic check_slot(int tag);
    int i = 0;
    while (i < q.size()) begin
      if (q[i].tag == tag) begin
        logic [31:0] a;
        a = actual(q[i].sel);
        total++;
        if (a !== q[i].val) begin
          bad++;
          $display("FAIL %s: got=%h want=%h (cycle %0d)", q[i].name, a, q[i].val, cyc);
        end
        q.delete(i);
      end else if (q[i].tag < tag) begin
        total++;
        bad++;
        $display("FAIL %s: got=<not sampled> want=%h", q[i].name, q[i].val);
        q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  // Monitor: slot A at the falling edge, slot B two time units later
  initial begin
    forever begin
      @(negedge clk);
      check_slot(2 * cyc);
      #2;
      check_slot(2 * cyc + 1);
    end
  end

  function automatic void push(int tag, int sel, logic [31:0] val, string name);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endfunction

  // Expectation on the state after the next rising edge
  function automatic void exp_next(int sel, logic [31:0] val, string name);
    push(2 * (cyc + 1), sel, val, name);
  endfunction

  function automatic void exp_reset(int tag, string name);
    push(tag, SEL_PC,    32'h0, {name, "_pc"});
    push(tag, SEL_INSTR, C_NOP, {name, "_instr"});
    push(tag, SEL_PC4,   32'h0, {name, "_pc4"});
    push(tag, SEL_NOOP,  32'h0, {name, "_noop"});
    push(tag, SEL_PRE,   32'h0, {name, "_prenoop"});
    push(tag, SEL_STALL, 32'h0, {name, "_stall"});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IF_noOp    = 1'b0;
    bus.IF_prenoOp = 1'b0;
    bus.pc_src     = 2'b00;
    bus.flush      = 1'b0;
  endtask

  initial begin
    cyc   = 0;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    bus.instr_in      = 32'h0;
    bus.branch_target = 32'h0;
    bus.jump_target   = 32'h0;
    bus.jr_target     = 32'h0;

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    exp_reset(2 * cyc, "por");
    reset = 1'b0;

    // One hold cycle so the counter is non-zero before the mid-run reset
    bus.IF_prenoOp = 1'b1;
    exp_next(SEL_PC,    32'h0, "pre_hold_pc");
    exp_next(SEL_STALL, 32'h1, "pre_hold_stall");
    exp_next(SEL_PRE,   32'h1, "pre_hold_idpre");
    step();

    // Jump to 0x48 while a hold is requested: redirect wins, no stall counted
    bus.IF_noOp     = 1'b1;
    bus.pc_src      = 2'b10;
    bus.jump_target = 32'h48;
    bus.instr_in    = 32'h1234_5678;
    exp_next(SEL_PC,    32'h48,        "jmp48_pc");
    exp_next(SEL_STALL, 32'h1,         "jmp48_stall");
    exp_next(SEL_NOOP,  32'h1,         "jmp48_idnoop");
    exp_next(SEL_INSTR, 32'h1234_5678, "jmp48_instr");
    exp_next(SEL_PC4,   32'h4,         "jmp48_pc4");
    step();

    // Mid-run async reset, observed before the next rising edge
    idle();
    @(negedge clk);
    #1;
    reset = 1'b1;
    exp_reset(2 * cyc + 1, "async");
    #3;
    reset = 1'b0;
    step();

    // Hold on IF_prenoOp at 0x10
    bus.pc_src      = 2'b10;
    bus.jump_target = 32'h10;
    exp_next(SEL_PC, 32'h10, "t2_jmp_pc");
    step();
    idle();
    bus.IF_prenoOp = 1'b1;
    exp_next(SEL_PC,    32'h10, "t2_hold_pc");
    exp_next(SEL_PRE,   32'h1,  "t2_idpre");
    exp_next(SEL_PC4,   32'h14, "t2_pc4");
    exp_next(SEL_STALL, 32'h1,  "t2_stall");
    step();
    idle();
    exp_next(SEL_PC,  32'h14, "t2_adv_pc");
    exp_next(SEL_PRE, 32'h0,  "t2_idpre_clr");
    step();

    // IF_noOp: advance, then hold on ID_noOp, then advance
    bus.pc_src      = 2'b10;
    bus.jump_target = 32'h20;
    exp_next(SEL_PC, 32'h20, "t3_jmp_pc");
    step();
    idle();
    bus.IF_noOp = 1'b1;
    exp_next(SEL_PC,   32'h24, "t3_adv_pc");
    exp_next(SEL_NOOP, 32'h1,  "t3_idnoop");
    exp_next(SEL_PC4,  32'h24, "t3_pc4");
    step();
    idle();
    exp_next(SEL_PC,    32'h24, "t3_hold_pc");
    exp_next(SEL_STALL, 32'h2,  "t3_stall");
    step();
    exp_next(SEL_PC, 32'h28, "t3_resume_pc");
    step();

    // JR redirect beats the ID_noOp hold; low bits forced to 00
    bus.IF_noOp = 1'b1;
    exp_next(SEL_PC,   32'h2C, "t4_pc");
    exp_next(SEL_NOOP, 32'h1,  "t4_idnoop");
    step();
    idle();
    bus.pc_src    = 2'b11;
    bus.jr_target = 32'h43;
    exp_next(SEL_PC,    32'h40, "t4_jr_pc");
    exp_next(SEL_STALL, 32'h2,  "t4_jr_stall");
    step();

    // Branch redirect together with IF_prenoOp: not counted
    idle();
    bus.pc_src        = 2'b01;
    bus.branch_target = 32'h101;
    bus.IF_prenoOp    = 1'b1;
    exp_next(SEL_PC,    32'h100, "br_pc");
    exp_next(SEL_STALL, 32'h2,   "br_stall");
    exp_next(SEL_PRE,   32'h1,   "br_idpre");
    step();
    idle();
    exp_next(SEL_PC, 32'h104, "br_adv_pc");
    step();

    // PC wrap at the top of the address space
    bus.pc_src      = 2'b10;
    bus.jump_target = 32'hFFFF_FFFC;
    exp_next(SEL_PC, 32'hFFFF_FFFC, "t5_jmp_pc");
    step();
    idle();
    exp_next(SEL_PC,  32'h0, "t5_wrap_pc");
    exp_next(SEL_PC4, 32'h0, "t5_wrap_pc4");
    step();

    // Flush squashes instruction and flags, PC still advances
    bus.flush    = 1'b1;
    bus.instr_in = 32'h8FFF_FFC8;
    bus.IF_noOp  = 1'b1;
    exp_next(SEL_INSTR, C_NOP, "t6_flush_instr");
    exp_next(SEL_NOOP,  32'h0, "t6_flush_noop");
    exp_next(SEL_PC4,   32'h4, "t6_flush_pc4");
    exp_next(SEL_PC,    32'h4, "t6_flush_pc");
    step();

    // Flush and hold together: both take effect
    bus.IF_noOp    = 1'b0;
    bus.IF_prenoOp = 1'b1;
    exp_next(SEL_PC,    32'h4, "t6_fh_pc");
    exp_next(SEL_PRE,   32'h0, "t6_fh_idpre");
    exp_next(SEL_INSTR, C_NOP, "t6_fh_instr");
    exp_next(SEL_STALL, 32'h3, "t6_fh_stall");
    step();

    // Long hold to saturate the stall counter
    bus.flush = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      if (i == 65530) exp_next(SEL_STALL, 32'hFFFE, "sat_pre");
      if (i == 65539) begin
        exp_next(SEL_STALL, 32'hFFFF, "sat_stall");
        exp_next(SEL_PC,    32'h4,    "sat_pc");
      end
      step();
    end
    idle();
    exp_next(SEL_STALL, 32'hFFFF, "sat_keep");
    exp_next(SEL_PC,    32'h8,    "sat_resume_pc");
    step();

    @(negedge clk);
    #4;
    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: got=<not sampled> want=%h", q[0].name, q[0].val);
      q.delete(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
